// File: rtl/encoder4a2_antirrebote.sv
// rtl/encoder4a2_antirrebote.sv - registered 4-to-2 one-hot encoder with synchronisers and debounce
module encoder4a2_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic pressed,
  output logic err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  // cnt reaching CNT_LAST means this sample completes the stable run
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [3:0]       sync1;
  logic [3:0]       v;
  state_t           state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       code, code_n;
  logic             valid_n;
  logic             pressed_n;
  logic             v_zero, v_one, v_multi, v_match;

  function automatic logic [1:0] encode(input logic [3:0] oh);
    logic [1:0] c;
    c = 2'b00;
    case (oh)
      4'b0001: c = 2'b00;
      4'b0010: c = 2'b01;
      4'b0100: c = 2'b10;
      4'b1000: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Two-flop synchroniser on every request line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 4'b0000;
      v     <= 4'b0000;
    end else begin
      sync1 <= {y3, y2, y1, y0};
      v     <= sync1;
    end
  end

  // Classify the synchronised lines; v & (v-1) clears the lowest set bit
  always_comb begin
    v_zero  = (v == 4'b0000);
    v_multi = ((v & (v - 4'd1)) != 4'b0000);
    v_one   = !v_zero && !v_multi;
    v_match = (v == cand);
  end

  // Next-state and next-output logic for the debounce FSM
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = code;
    valid_n   = 1'b0;
    pressed_n = pressed;
    case (state)
      IDLE: begin
        if (v_one) begin
          cand_n  = v;
          cnt_n   = CNT_ONE;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (v_match) begin
          if (cnt == CNT_LAST) begin
            code_n    = encode(cand);
            valid_n   = 1'b1;
            pressed_n = 1'b1;
            state_n   = HOLD;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          cnt_n   = CNT_ZERO;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (!v_match) begin
          cnt_n   = v_zero ? CNT_ONE : CNT_ZERO;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (v_zero) begin
          if (cnt == CNT_LAST) begin
            pressed_n = 1'b0;
            cnt_n     = CNT_ZERO;
            state_n   = IDLE;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else if (v_match) begin
          state_n = HOLD;
        end else begin
          // a different key must be fully released before anything new is accepted
          cnt_n = CNT_ZERO;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= 4'b0000;
      cnt     <= CNT_ZERO;
      code    <= 2'b00;
      valid   <= 1'b0;
      pressed <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      code    <= code_n;
      valid   <= valid_n;
      pressed <= pressed_n;
      err     <= v_multi;
    end
  end

  assign s1 = code[1];
  assign s0 = code[0];

endmodule

// File: tb/tb_encoder4a2_antirrebote.sv
// tb/tb_encoder4a2_antirrebote.sv - scoreboard bench for encoder4a2_antirrebote
module tb_encoder4a2_antirrebote;

  logic       clk;
  logic       rst_n;
  logic [3:0] y;
  logic       s1, s0, valid, pressed, err;

  int         checks;
  int         errors;
  logic [1:0] exp_q[$];

  encoder4a2_antirrebote #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .y0(y[0]),
    .y1(y[1]),
    .y2(y[2]),
    .y3(y[3]),
    .s1(s1),
    .s0(s0),
    .valid(valid),
    .pressed(pressed),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: every valid pulse must match the oldest queued expected code
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid actual s1s0=%b expected no valid", {s1, s0});
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({s1, s0} !== e) begin
          errors++;
          $display("FAIL valid_code actual %b expected %b", {s1, s0}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges until valid is seen, counting the first edge after the call as 1
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) break;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual none expected pulse within 20 edges");
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    y      = 4'b0000;
    step(2);
    check("reset_s1s0", {30'd0, s1, s0}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_pressed", {31'd0, pressed}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1: y2 held steady
    y = 4'b0100;
    exp_q.push_back(2'b10);
    wait_valid(n);
    check("press_latency", n, 6);
    check("press_s1s0", {30'd0, s1, s0}, 32'h2);
    check("press_pressed", {31'd0, pressed}, 32'd1);
    check("press_err", {31'd0, err}, 32'd0);
    step(1);
    check("valid_one_cycle", {31'd0, valid}, 32'd0);

    y = 4'b0000;
    step(10);
    check("release1_pressed", {31'd0, pressed}, 32'd0);
    check("release1_keeps_code", {30'd0, s1, s0}, 32'h2);

    // 2: bounces of 2 and 3 cycles are rejected
    y = 4'b0010;
    step(2);
    y = 4'b0000;
    step(10);
    check("bounce2_pressed", {31'd0, pressed}, 32'd0);
    check("bounce2_code", {30'd0, s1, s0}, 32'h2);
    y = 4'b0010;
    step(3);
    y = 4'b0000;
    step(10);
    check("bounce3_pressed", {31'd0, pressed}, 32'd0);
    check("bounce3_code", {30'd0, s1, s0}, 32'h2);

    // 3: two lines active together
    y = 4'b1001;
    step(2);
    check("multi_err_before_e2", {31'd0, err}, 32'd0);
    step(1);
    check("multi_err_after_e2", {31'd0, err}, 32'd1);
    step(8);
    check("multi_err_held", {31'd0, err}, 32'd1);
    check("multi_pressed", {31'd0, pressed}, 32'd0);
    y = 4'b0000;
    step(3);
    check("multi_err_clear", {31'd0, err}, 32'd0);
    step(5);

    // 4: release glitch while holding y3
    y = 4'b1000;
    exp_q.push_back(2'b11);
    wait_valid(n);
    check("y3_latency", n, 6);
    step(3);
    y = 4'b0000;
    step(2);
    y = 4'b1000;
    step(10);
    check("glitch_pressed", {31'd0, pressed}, 32'd1);
    check("glitch_code", {30'd0, s1, s0}, 32'h3);

    // 5: full release then a new key
    y = 4'b0000;
    step(5);
    check("release_not_yet", {31'd0, pressed}, 32'd1);
    step(1);
    check("release_done", {31'd0, pressed}, 32'd0);
    check("release_keeps_y3", {30'd0, s1, s0}, 32'h3);
    step(3);
    y = 4'b0010;
    exp_q.push_back(2'b01);
    wait_valid(n);
    check("y1_latency", n, 6);
    check("y1_code", {30'd0, s1, s0}, 32'h1);
    y = 4'b0000;
    step(10);

    // 6: reset during HOLD with y2 still held
    y = 4'b0100;
    exp_q.push_back(2'b10);
    wait_valid(n);
    step(3);
    rst_n = 1'b0;
    step(1);
    check("midreset_s1s0", {30'd0, s1, s0}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_pressed", {31'd0, pressed}, 32'd0);
    check("midreset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(2'b10);
    wait_valid(n);
    check("post_reset_latency", n, 6);
    check("post_reset_pressed", {31'd0, pressed}, 32'd1);

    // Switching to another key while held needs a full release first
    step(2);
    y = 4'b0001;
    step(12);
    check("switch_pressed", {31'd0, pressed}, 32'd1);
    check("switch_code", {30'd0, s1, s0}, 32'h2);
    y = 4'b0000;
    step(10);
    check("switch_release", {31'd0, pressed}, 32'd0);

    step(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder4a2_antirrebote.md
Name: encoder4a2_antirrebote

Overview:
Registered 4-to-2 one-hot encoder with input synchronisation and debounce. It is the inverse of the team's 1-of-4 line decoder: four request lines (buttons or one-hot select lines) y0..y3 are encoded back to a 2-bit code s1s0. A code is reported only after the request has been stable for a programmable number of clock cycles. The block sits between raw board inputs and any logic that consumes a key/select code.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release; legal range 2..(2**CNT_W - 1)
CNT_W, 3, width of the debounce counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
y0  input  1  request line 0, asynchronous to clk
y1  input  1  request line 1, asynchronous to clk
y2  input  1  request line 2, asynchronous to clk
y3  input  1  request line 3, asynchronous to clk
s1  output  1  code MSB, registered
s0  output  1  code LSB, registered
valid  output  1  one-cycle pulse when a new code is accepted
pressed  output  1  level; high while the accepted request is held
err  output  1  level; high while two or more synchronised lines are active

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low; clk and rst_n are the port names.
- Reset: on any edge with rst_n=0, clear all of the following:
  - s1, s0, valid, pressed, err, the synchronisers and cnt all go to 0; cand goes to 00.
  - State goes to IDLE.
  - Reset dominates all other conditions.
- Synchroniser: 2-flop synchroniser per line; v[3:0] is the stage-2 output. y sampled at edge E0 is visible as v after E1.
- Code map (inverse of the decoder): y0->00, y1->01, y2->10, y3->11.
- Classification of v: ZERO (0000), ONE (exactly one bit set), MULTI (two or more bits set).
- err: err <= (v is MULTI) at every edge, in all states.
- FSM states: IDLE, DEBOUNCE, HOLD, RELEASE. cand is a 4-bit register holding the candidate one-hot value.
- IDLE:
  - v ONE: cand<=v, cnt<=1, go to DEBOUNCE.
  - v ZERO or MULTI: stay in IDLE.
- DEBOUNCE:
  - v==cand and cnt==DEBOUNCE_CYCLES-1: s1s0<=encode(cand), valid<=1, pressed<=1, go to HOLD.
  - v==cand, otherwise: cnt<=cnt+1.
  - v!=cand (including MULTI or ZERO): cnt<=0, go to IDLE. s1s0 is unchanged.
- HOLD:
  - v==cand: stay in HOLD.
  - v ZERO: cnt<=1, go to RELEASE.
  - any other v: cnt<=0, go to RELEASE.
- RELEASE:
  - v ZERO and cnt==DEBOUNCE_CYCLES-1: pressed<=0, cnt<=0, go to IDLE.
  - v ZERO, otherwise: cnt<=cnt+1.
  - v==cand: go to HOLD; no new valid pulse.
  - any other nonzero v: cnt<=0, stay in RELEASE. A full release is required before a new key is accepted.
- valid: high for exactly one cycle per accepted press, and is 0 in every other cycle.
- Latency: y stable before E0 gives valid=1 in the cycle after edge E(DEBOUNCE_CYCLES+1). With the default parameters valid is asserted after E5.
- Release latency: pressed falls after DEBOUNCE_CYCLES consecutive ZERO samples of v.
- s1s0: holds the last accepted code, including after release; it changes only on accept or reset.
- Reset mid-operation: a key held across reset must be debounced again in full and then produces a fresh valid pulse.

Test Plan:
1. Reset, then y2=1 held steady: valid=1 for one cycle after E5 (N=4), s1s0=10, pressed=1, err=0.
2. Bounce rejection: y1=1 for 2 cycles, then 0: valid never asserts, pressed=0, s1s0 keeps its previous value.
3. Multi-active: y0=y3=1: err=1 from the cycle after E2 while held, valid never asserts, FSM stays in IDLE.
4. Release glitch: while HOLD on y3, drop y3 for 2 cycles, then restore: pressed stays 1, no second valid, s1s0=11.
5. Full release, then new key: y3=0 for 4+ cycles gives pressed=0; then y1 held gives valid pulse with s1s0=01.
6. Reset mid-operation: rst_n=0 for one edge during HOLD with y2 held: all outputs 0 next cycle; after rst_n=1, valid reasserts 6 edges later with s1s0=10.
